// File: rtl/uart_alu_host.sv
// Host-side sequencer for a UART-attached ALU: sends A, B and the opcode as three
// bytes, then waits for the one-byte result, giving up after TIMEOUT cycles.
module uart_alu_host #(
  parameter int N_DATA       = 8,
  parameter int NB_OPERATION = 6,
  parameter int TIMEOUT      = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  input  logic [N_DATA-1:0]       i_cmd_a,
  input  logic [N_DATA-1:0]       i_cmd_b,
  input  logic [NB_OPERATION-1:0] i_cmd_op,
  output logic                    o_cmd_ready,
  output logic [N_DATA-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  input  logic [N_DATA-1:0]       i_rx_data,
  input  logic                    i_rx_done,
  output logic [N_DATA-1:0]       o_result,
  output logic                    o_result_valid,
  output logic                    o_timeout,
  output logic                    o_busy
);

  localparam int              CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX_START = 2'd1,
    ST_TX_WAIT  = 2'd2,
    ST_RX_WAIT  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_idx;
  logic [N_DATA-1:0]       r_a;
  logic [N_DATA-1:0]       r_b;
  logic [NB_OPERATION-1:0] r_op;
  logic [CW-1:0]           r_cnt;
  logic [N_DATA-1:0]       r_result;
  logic                    r_result_valid;
  logic                    r_timeout;

  logic [N_DATA-1:0]       w_op_ext;
  logic [N_DATA-1:0]       w_tx_data;

  // Select the outgoing byte from the captured operands by byte index.
  always_comb begin
    w_op_ext                   = '0;
    w_op_ext[NB_OPERATION-1:0] = r_op;
    case (r_idx)
      2'd0:    w_tx_data = r_a;
      2'd1:    w_tx_data = r_b;
      2'd2:    w_tx_data = w_op_ext;
      default: w_tx_data = '0;
    endcase
  end

  // Command sequencing FSM with result/timeout pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= 2'd0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_a     <= i_cmd_a;
            r_b     <= i_cmd_b;
            r_op    <= i_cmd_op;
            r_idx   <= 2'd0;
            r_state <= ST_TX_START;
          end
        end
        ST_TX_START: r_state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (i_tx_done) begin
            if (r_idx == 2'd2) begin
              r_cnt   <= '0;
              r_state <= ST_RX_WAIT;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_TX_START;
            end
          end
        end
        ST_RX_WAIT: begin
          // A result arriving on the expiry cycle takes priority over the timeout.
          if (i_rx_done) begin
            r_result       <= i_rx_data;
            r_result_valid <= 1'b1;
            r_state        <= ST_IDLE;
          end else if (r_cnt == C_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready    = (r_state == ST_IDLE);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_tx_start     = (r_state == ST_TX_START);
  assign o_tx_data      = w_tx_data;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_uart_alu_host.sv
// Randomised and directed bench for uart_alu_host, checked every cycle against a
// byte-queue transaction model of the host.
module tb_uart_alu_host;
  localparam int ND = 8;
  localparam int NO = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [ND-1:0] cmd_a = '0;
  logic [ND-1:0] cmd_b = '0;
  logic [NO-1:0] cmd_op = '0;
  logic          tx_done = 1'b0;
  logic [ND-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic          o_cmd_ready, o_tx_start, o_result_valid, o_timeout, o_busy;
  logic [ND-1:0] o_tx_data, o_result;

  uart_alu_host #(.N_DATA(ND), .NB_OPERATION(NO), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd_a(cmd_a),
    .i_cmd_b(cmd_b), .i_cmd_op(cmd_op), .o_cmd_ready(o_cmd_ready),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(tx_done),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .o_result(o_result),
    .o_result_valid(o_result_valid), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ND-1:0] tx_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: a command is a queue of bytes still to send, then a wait for one result byte.
  bit            m_busy, m_start, m_rv, m_to;
  logic [ND-1:0] m_q[$];
  logic [ND-1:0] m_txd, m_result;
  int            m_wait;

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_start = 0; m_rv = 0; m_to = 0; m_wait = 0;
      m_q.delete(); m_txd = '0; m_result = '0;
    end else begin
      m_rv = 0; m_to = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_q.delete();
          m_q.push_back(cmd_a);
          m_q.push_back(cmd_b);
          m_q.push_back({2'b00, cmd_op});
          m_txd = cmd_a; m_busy = 1; m_start = 1;
        end
      end else if (m_start) begin
        m_start = 0;
      end else if (m_q.size() != 0) begin
        if (tx_done) begin
          void'(m_q.pop_front());
          if (m_q.size() != 0) begin
            m_start = 1; m_txd = m_q[0];
          end else begin
            m_wait = 0;
          end
        end
      end else begin
        m_wait++;
        if (rx_done) begin
          m_result = rx_data; m_rv = 1; m_busy = 0;
        end else if (m_wait == TO) begin
          m_to = 1; m_busy = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("cmd_ready", o_cmd_ready, !m_busy);
      chk("busy", o_busy, m_busy);
      chk("tx_start", o_tx_start, m_start);
      chk("result", o_result, m_result);
      chk("result_valid", o_result_valid, m_rv);
      chk("timeout", o_timeout, m_to);
      if (m_busy && m_q.size() != 0) chk("tx_data", o_tx_data, m_txd);
      if (o_tx_start) tx_log.push_back(o_tx_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [ND-1:0] a, input logic [ND-1:0] b, input logic [NO-1:0] op);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic serve_tx(input int lat);
    int t;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (o_tx_start !== 1'b1 && t < 40) begin
        tick();
        t++;
      end
      if (t >= 40) begin
        chk("tx_start_wait", o_tx_start, 1'b1);
        return;
      end
      repeat (lat) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  task automatic rx_reply(input int delay, input logic [ND-1:0] data);
    repeat (delay - 1) tick();
    rx_done = 1'b1; rx_data = data;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, o_tx_start, 1'b0);
    chk({tag, "_tx_data"}, o_tx_data, 8'h00);
    chk({tag, "_result"}, o_result, 8'h00);
    chk({tag, "_result_valid"}, o_result_valid, 1'b0);
    chk({tag, "_timeout"}, o_timeout, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
  endtask

  initial begin
    int c;
    int d;
    #3;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Basic command
    tx_log.delete();
    send_cmd(8'h05, 8'h03, 6'h20);
    serve_tx(10);
    rx_reply(5, 8'h08);
    chk("basic_result", o_result, 8'h08);
    chk("basic_valid", o_result_valid, 1'b1);
    tick();
    chk("basic_valid_single", o_result_valid, 1'b0);
    chk("basic_starts", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk("basic_byte0", tx_log[0], 8'h05);
      chk("basic_byte1", tx_log[1], 8'h03);
      chk("basic_byte2", tx_log[2], 8'h20);
    end

    // Opcode zero-extension
    tx_log.delete();
    send_cmd(8'h11, 8'h22, 6'h3F);
    serve_tx(3);
    if (tx_log.size() == 3) chk("opext_byte2", tx_log[2], 8'h3F);
    else chk("opext_starts", tx_log.size(), 3);
    rx_reply(2, 8'h5C);
    chk("opext_result", o_result, 8'h5C);

    // Timeout
    send_cmd(8'h01, 8'h02, 6'h03);
    serve_tx(2);
    c = 0;
    while (o_timeout !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    chk("timeout_cycles", c, 16);
    chk("timeout_result_kept", o_result, 8'h5C);
    chk("timeout_no_valid", o_result_valid, 1'b0);
    tick();
    chk("timeout_ready_after", o_cmd_ready, 1'b1);

    // Result on the expiry cycle
    send_cmd(8'h0A, 8'h0B, 6'h0C);
    serve_tx(1);
    rx_reply(16, 8'hAA);
    chk("tie_result", o_result, 8'hAA);
    chk("tie_valid", o_result_valid, 1'b1);
    chk("tie_timeout", o_timeout, 1'b0);

    // Spurious handshakes in IDLE and cmd_valid held through a transfer
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0; rx_data = 8'h77; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("spur_ready", o_cmd_ready, 1'b1);
    chk("spur_result", o_result, 8'hAA);
    tx_log.delete();
    cmd_valid = 1'b1; cmd_a = 8'h31; cmd_b = 8'h32; cmd_op = 6'h33;
    tick();
    serve_tx(4);
    cmd_valid = 1'b0;
    chk("hold_starts", tx_log.size(), 3);
    rx_reply(3, 8'h42);
    chk("hold_result", o_result, 8'h42);

    // Reset in the middle of the second byte
    tick();
    send_cmd(8'hA1, 8'hB2, 6'h0C);
    chk("mid_first_start", o_tx_start, 1'b1);
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("mid_second_byte", o_tx_data, 8'hB2);
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    tick();
    rst = 1'b0;
    tx_log.delete();
    send_cmd(8'h3C, 8'h4D, 6'h2A);
    serve_tx(2);
    chk("restart_starts", tx_log.size(), 3);
    if (tx_log.size() == 3) chk("restart_byte0", tx_log[0], 8'h3C);
    rx_reply(4, 8'h99);
    chk("restart_result", o_result, 8'h99);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin
        tx_done = 1'($urandom_range(0, 1));
        rx_done = 1'($urandom_range(0, 1));
        rx_data = 8'($urandom);
        tick();
      end
      tx_done = 1'b0; rx_done = 1'b0;
      send_cmd(8'($urandom), 8'($urandom), 6'($urandom));
      serve_tx($urandom_range(1, 12));
      d = $urandom_range(1, 22);
      rx_reply(d, 8'($urandom));
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_alu_host.md
UART_ALU_HOST -- requirements
Module: uart_alu_host

Interface
REQ-001 The block SHALL have parameter N_DATA, default 8, the UART data byte width and the operand width.
REQ-002 The block SHALL have parameter NB_OPERATION, default 6, the ALU opcode width (NB_OPERATION <= N_DATA).
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, the number of clock cycles allowed for the result byte.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have the following ports (clock and reset first):
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- i_cmd_a  in  N_DATA  operand A.
- i_cmd_b  in  N_DATA  operand B.
- i_cmd_op  in  NB_OPERATION  ALU opcode.
- o_cmd_ready  out  1  high only in IDLE.
- o_tx_data  out  N_DATA  byte to the UART transmitter.
- o_tx_start  out  1  one-cycle pulse; starts transmission of o_tx_data.
- i_tx_done  in  1  one-cycle pulse; UART byte sent.
- i_rx_data  in  N_DATA  byte from the UART receiver.
- i_rx_done  in  1  one-cycle pulse; i_rx_data is valid.
- o_result  out  N_DATA  last ALU result received.
- o_result_valid  out  1  one-cycle pulse; o_result updated.
- o_timeout  out  1  one-cycle pulse; result not received in time.
- o_busy  out  1  high in any state other than IDLE.

Function
REQ-006 The FSM SHALL have four states: IDLE, TX_START, TX_WAIT and RX_WAIT, plus a 2-bit byte index idx with values 0, 1 and 2.
REQ-007 In IDLE, i_cmd_valid=1 SHALL capture A, B and OP into internal registers, set idx=0, and move to TX_START; i_cmd_valid is ignored in every other state.
REQ-008 In TX_START, o_tx_start SHALL be 1 for exactly one cycle, and the FSM SHALL move to TX_WAIT on the next edge.
REQ-009 o_tx_data SHALL equal A when idx=0, B when idx=1, and OP zero-extended to N_DATA when idx=2.
REQ-010 o_tx_data SHALL stay stable from the TX_START cycle until i_tx_done is accepted.
REQ-011 In TX_WAIT, i_tx_done=1 with idx<2 SHALL increment idx and return to TX_START, so the next o_tx_start comes exactly 1 cycle after i_tx_done.
REQ-012 In TX_WAIT, i_tx_done=1 with idx=2 SHALL clear the timeout counter and move to RX_WAIT.
REQ-013 An i_tx_done pulse outside TX_WAIT SHALL be ignored.
REQ-014 In RX_WAIT, i_rx_done=1 SHALL register i_rx_data into o_result, pulse o_result_valid on the next cycle, and return to IDLE.
REQ-015 An i_rx_done pulse outside RX_WAIT SHALL be ignored, with o_result unchanged.
REQ-016 In RX_WAIT, the timeout counter SHALL increment every cycle without i_rx_done.
REQ-017 When the timeout counter reaches TIMEOUT-1 without i_rx_done, the block SHALL pulse o_timeout for one cycle and return to IDLE, with o_result unchanged.
REQ-018 If i_rx_done arrives in the same cycle as timeout expiry, the result SHALL win: o_result_valid=1 and o_timeout=0.
REQ-019 The timeout counter SHALL be wide enough for TIMEOUT and SHALL never wrap.
REQ-020 o_result_valid and o_timeout SHALL never be 1 in the same cycle.
REQ-021 o_tx_start SHALL be 0 outside TX_START.
REQ-022 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-023 Asserting i_rst SHALL immediately force the following, from any state including mid-transfer, with no pending byte resumed: state=IDLE, idx=0, counter=0, o_tx_start=0, o_tx_data=0, o_result=0, o_result_valid=0, o_timeout=0, o_busy=0, o_cmd_ready=1.
REQ-024 After i_rst deasserts, the first command SHALL be accepted on the first rising edge with i_cmd_valid=1.

Verification
REQ-025 Basic command: A=0x05, B=0x03, OP=0x20, with i_tx_done returned 10 cycles after each o_tx_start -> o_tx_data sequence 0x05, 0x03, 0x20 with exactly 3 o_tx_start pulses; then i_rx_done with 0x08 -> o_result=0x08 and a single o_result_valid pulse.
REQ-026 Op zero-extension: OP=0x3F -> third byte is 0x3F, upper bits 0.
REQ-027 Timeout: TIMEOUT=16 and no i_rx_done -> o_timeout pulses 16 cycles after RX_WAIT entry; o_result keeps its prior value; o_cmd_ready=1 on the next cycle.
REQ-028 Tie case: i_rx_done=1 with 0xAA on the expiry cycle -> o_result=0xAA, o_result_valid=1, o_timeout=0.
REQ-029 Spurious inputs: i_tx_done and i_rx_done pulsed in IDLE, and i_cmd_valid held high during TX_WAIT -> no state change and no second command.
REQ-030 Reset mid-operation: i_rst asserted during TX_WAIT for idx=1 -> all outputs reach their reset values without waiting for a clock edge; a new command afterwards starts again at byte A.
